// File: rtl/int_pkg.sv
// Shared types and defaults for the three-source interrupt controller.
// Holds the request FSM state encoding and the default entrance vectors.
package int_pkg;

    localparam int N_SRC = 3;

    localparam logic [31:0] VEC2 = 32'h0000_0400;
    localparam logic [31:0] VEC1 = 32'h0000_0600;
    localparam logic [31:0] VEC0 = 32'h0000_0800;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

endpackage

// File: rtl/int_prio_enc3.sv
// Highest-set-bit encoder over three request bits; bit 2 has priority.
// Latency: combinational; backpressure: none (pure function of its input).
module int_prio_enc3 (
    input  logic [2:0] bits,
    output logic [1:0] idx,
    output logic       vld
);

    always_comb begin
        vld = |bits;
        idx = 2'd0;
        if (bits[2]) begin
            idx = 2'd2;
        end else if (bits[1]) begin
            idx = 2'd1;
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-latched, priority-nested interrupt requester facing the CPU pipeline.
// Latency: 2 cycles from source rise to int_req; backpressure: request held frozen until int_ack or withdraw.
module interrupt_controller
    import int_pkg::*;
#(
    parameter int          N_SRC = int_pkg::N_SRC,
    parameter logic [31:0] VEC2  = int_pkg::VEC2,
    parameter logic [31:0] VEC1  = int_pkg::VEC1,
    parameter logic [31:0] VEC0  = int_pkg::VEC0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [N_SRC-1:0] int_mask,
    input  logic             int_disable,
    input  logic             int_ack,
    input  logic             int_eret,
    output logic             int_req,
    output logic [1:0]       int_id,
    output logic [31:0]      int_vector,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] in_service
);

    state_t           state;
    logic [N_SRC-1:0] src_d;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] above_top;
    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] ack_set;
    logic [N_SRC-1:0] eret_clr;
    logic [1:0]       top_idx;
    logic             top_vld;
    logic [1:0]       win_idx;
    logic             win_vld;
    logic             ack_fire;
    logic             withdraw;

    function automatic logic [31:0] vec_of(input logic [1:0] idx);
        case (idx)
            2'd2:    vec_of = VEC2;
            2'd1:    vec_of = VEC1;
            default: vec_of = VEC0;
        endcase
    endfunction

    int_prio_enc3 u_top_enc (
        .bits (in_service),
        .idx  (top_idx),
        .vld  (top_vld)
    );

    int_prio_enc3 u_win_enc (
        .bits (elig),
        .idx  (win_idx),
        .vld  (win_vld)
    );

    assign rise = irq_src & ~src_d;

    // Only sources strictly above the current in-service level may nest.
    always_comb begin
        above_top = 3'b111;
        if (top_vld) begin
            case (top_idx)
                2'd0:    above_top = 3'b110;
                2'd1:    above_top = 3'b100;
                default: above_top = 3'b000;
            endcase
        end
    end

    assign elig     = pending & int_mask & {N_SRC{~int_disable}} & above_top;
    assign ack_fire = (state == REQ) && int_ack;
    assign withdraw = (state == REQ) && !int_ack && (int_disable || !int_mask[int_id]);
    assign ack_set  = ack_fire ? (3'b001 << int_id) : 3'b000;
    assign eret_clr = (int_eret && top_vld) ? (3'b001 << top_idx) : 3'b000;
    assign int_req  = (state == REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_d      <= '0;
            pending    <= '0;
            in_service <= '0;
        end else begin
            src_d      <= irq_src;
            pending    <= (pending & ~ack_set) | rise;
            in_service <= (in_service & ~eret_clr) | ack_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            int_id     <= 2'd0;
            int_vector <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state      <= REQ;
                        int_id     <= win_idx;
                        int_vector <= vec_of(win_idx);
                    end
                end
                REQ: begin
                    if (ack_fire || withdraw) begin
                        state      <= IDLE;
                        int_id     <= 2'd0;
                        int_vector <= 32'd0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    int_id     <= 2'd0;
                    int_vector <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench: a stack-based reference model predicts every post-edge output set.
// Directed scenarios first, then randomized traffic; a monitor compares each cycle.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  irq_src;
    logic [2:0]  int_mask;
    logic        int_disable;
    logic        int_ack;
    logic        int_eret;
    logic        int_req;
    logic [1:0]  int_id;
    logic [31:0] int_vector;
    logic [2:0]  pending;
    logic [2:0]  in_service;

    always #5 clk = ~clk;

    interrupt_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_src     (irq_src),
        .int_mask    (int_mask),
        .int_disable (int_disable),
        .int_ack     (int_ack),
        .int_eret    (int_eret),
        .int_req     (int_req),
        .int_id      (int_id),
        .int_vector  (int_vector),
        .pending     (pending),
        .in_service  (in_service)
    );

    typedef struct {
        logic        req;
        logic [1:0]  id;
        logic [31:0] vec;
        logic [2:0]  pend;
        logic [2:0]  isv;
    } snap_t;

    snap_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    // Reference model: in-service levels kept as a stack of source numbers.
    logic [2:0] m_prev;
    logic [2:0] m_pend;
    int         m_stack[$];
    bit         m_req;
    int         m_id;

    function automatic logic [31:0] vec_of(input int id);
        if (id == 2) return 32'h0000_0400;
        if (id == 1) return 32'h0000_0600;
        return 32'h0000_0800;
    endfunction

    task automatic model_reset();
        m_prev = 3'b000;
        m_pend = 3'b000;
        m_stack.delete();
        m_req  = 1'b0;
        m_id   = 0;
    endtask

    task automatic model_step(input logic [2:0] irq, input logic [2:0] mask,
                              input logic dis, input logic ack, input logic eret);
        int         top;
        int         win;
        bit         do_ack;
        logic [2:0] rise;
        top    = (m_stack.size() > 0) ? m_stack[$] : -1;
        do_ack = m_req && ack;
        win    = -1;
        for (int i = 0; i < 3; i++)
            if (m_pend[i] && mask[i] && !dis && i > top) win = i;
        rise = irq & ~m_prev;
        if (eret && m_stack.size() > 0) void'(m_stack.pop_back());
        if (do_ack) begin
            m_stack.push_back(m_id);
            m_pend[m_id] = 1'b0;
        end
        m_pend = m_pend | rise;
        if (m_req) begin
            if (do_ack || dis || !mask[m_id]) begin
                m_req = 1'b0;
                m_id  = 0;
            end
        end else if (win >= 0) begin
            m_req = 1'b1;
            m_id  = win;
        end
        m_prev = irq;
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.req  = m_req;
        s.id   = m_id[1:0];
        s.vec  = m_req ? vec_of(m_id) : 32'd0;
        s.pend = m_pend;
        s.isv  = 3'b000;
        foreach (m_stack[k]) s.isv[m_stack[k]] = 1'b1;
        return s;
    endfunction

    // Called just after a falling edge; returns at the next falling edge.
    task automatic step(input logic [2:0] irq, input logic ack = 1'b0, input logic eret = 1'b0,
                        input logic dis = 1'b0, input logic [2:0] mask = 3'b111);
        irq_src     = irq;
        int_mask    = mask;
        int_disable = dis;
        int_ack     = ack;
        int_eret    = eret;
        model_step(irq, mask, dis, ack, eret);
        exp_q.push_back(model_snap());
        @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        tests++;
        if (int_req !== 1'b0 || int_id !== 2'd0 || int_vector !== 32'd0 ||
            pending !== 3'b000 || in_service !== 3'b000) begin
            fails++;
            $display("FAIL %s: got req=%b id=%0d vec=%h pend=%b isv=%b, want all zero",
                     name, int_req, int_id, int_vector, pending, in_service);
        end
    endtask

    initial begin : monitor
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (int_req !== e.req || int_id !== e.id || int_vector !== e.vec ||
                    pending !== e.pend || in_service !== e.isv) begin
                    fails++;
                    $display("FAIL cycle t=%0t: got req=%b id=%0d vec=%h pend=%b isv=%b, want req=%b id=%0d vec=%h pend=%b isv=%b",
                             $time, int_req, int_id, int_vector, pending, in_service,
                             e.req, e.id, e.vec, e.pend, e.isv);
                end
            end
        end
    end

    initial begin : stim
        logic [2:0] cur_irq;
        rst_n = 1'b0;
        irq_src = 3'b000; int_mask = 3'b111; int_disable = 1'b0;
        int_ack = 1'b0;   int_eret = 1'b0;
        model_reset();
        #2 check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Single source: request, ack, return.
        step(3'b010); step(3'b000); step(3'b000);
        step(3'b000, 1'b1);
        step(3'b000, 1'b0, 1'b1);
        step(3'b000);

        // Priority and nesting: 2 wins, 0 waits until 2 returns.
        step(3'b101); step(3'b000); step(3'b000);
        step(3'b000, 1'b1);
        step(3'b000); step(3'b000); step(3'b000);
        step(3'b000, 1'b0, 1'b1);
        step(3'b000); step(3'b000);
        step(3'b000, 1'b1);

        // Preemption over in-service level 0, then two returns.
        step(3'b100); step(3'b000); step(3'b000);
        step(3'b000, 1'b1);
        step(3'b000, 1'b0, 1'b1);
        step(3'b000, 1'b0, 1'b1);
        step(3'b000);

        // Withdraw by global disable, then re-request.
        step(3'b010); step(3'b000); step(3'b000);
        step(3'b000, 1'b0, 1'b0, 1'b1);
        step(3'b000); step(3'b000);
        step(3'b000, 1'b0, 1'b0, 1'b0, 3'b101);
        step(3'b000); step(3'b000);
        step(3'b000, 1'b1);
        step(3'b000, 1'b0, 1'b1);

        // Boundaries: ack in IDLE, eret with nothing in service, rise on ack edge.
        step(3'b000, 1'b1);
        step(3'b000, 1'b0, 1'b1);
        step(3'b010); step(3'b000); step(3'b000);
        step(3'b010, 1'b1);
        step(3'b000); step(3'b000);
        step(3'b000, 1'b0, 1'b1);
        step(3'b000); step(3'b000);
        step(3'b000, 1'b1);
        step(3'b000, 1'b0, 1'b1);
        step(3'b000);

        // Asynchronous reset in the middle of a request.
        step(3'b100); step(3'b000); step(3'b000);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset_mid_req");
        exp_q.delete();
        model_reset();
        irq_src = 3'b100;
        @(negedge clk);
        rst_n = 1'b1;
        step(3'b100); step(3'b100); step(3'b100);
        step(3'b100, 1'b1);
        step(3'b000, 1'b0, 1'b1);
        step(3'b000);

        // Randomized traffic.
        cur_irq = 3'b000;
        for (int n = 0; n < 1500; n++) begin
            logic [2:0] mask;
            if ($urandom_range(0, 3) == 0) cur_irq = 3'($urandom_range(0, 7));
            mask = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            step(cur_irq, ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 11) == 0), mask);
        end

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Device-side end of the CPU interrupt interface. It edge-detects three device request lines and latches them as pending. It arbitrates by fixed priority against the CP0 mask and global-disable bits, and presents one frozen request with its entrance vector to the pipeline until the pipeline acknowledges it. It then tracks in-service levels so that only strictly higher-priority sources can nest, and unwinds one level per exception return.

## Interface
Parameters:
- N_SRC, 3, number of sources; fixed at 3, source 2 highest priority.
- VEC2, 32'h0000_0400, entrance address for source 2.
- VEC1, 32'h0000_0600, entrance address for source 1.
- VEC0, 32'h0000_0800, entrance address for source 0.

Ports:
- clk  in  1  rising-edge clock (same gated clk as the pipeline).
- rst_n  in  1  reset; asynchronous, active-low.
- irq_src  in  3  device request levels, synchronous to clk.
- int_mask  in  3  CP0 mask; bit i = 1 enables source i.
- int_disable  in  1  CP0 global disable; 1 blocks new requests.
- int_ack  in  1  pipeline accepts the presented request this cycle.
- int_eret  in  1  pipeline retires an exception return this cycle.
- int_req  out  1  request to pipeline, registered.
- int_id  out  2  index of the presented source, held stable while int_req = 1.
- int_vector  out  32  entrance address for int_id, held stable while int_req = 1.
- pending  out  3  latched, not-yet-acknowledged edges.
- in_service  out  3  acknowledged, not-yet-returned levels.

## Operation
- Edge detect:
  - src_d <= irq_src every cycle.
  - rise = irq_src & ~src_d.
  - pending[i] is set on rise[i].
  - pending[i] is cleared on acknowledge of i.
  - Set wins if both happen on the same edge.
- Eligibility, computed from registered values:
  - elig[i] = pending[i] & int_mask[i] & ~int_disable & (i > top), where top is the highest set in_service index, or -1 if none.
  - The winner is the highest eligible index.
- FSM, two states:
  - IDLE -> REQ when any source is eligible. The winner is captured into int_id, and int_vector is loaded from VECn.
  - REQ -> IDLE on int_ack.
    - Clears pending[int_id] unless a new rise occurs on the same edge.
    - Sets in_service[int_id].
  - REQ -> IDLE (withdraw) when int_disable = 1 or int_mask[int_id] = 0. Pending and in_service are unchanged.
  - In REQ, a newly eligible higher source does not replace the frozen request. It is presented after this request's ack or withdraw.
- int_ack while in IDLE is ignored.
- int_eret clears the highest set in_service bit. It is ignored when in_service = 0.
- Simultaneous int_eret and int_ack: the eret clear is applied to the old in_service first, then the ack bit is set.
- int_req = (state == REQ). int_id and int_vector are zero in IDLE.

## Timing
- Reset (async assert, sync release): state IDLE; int_req 0; int_id 0; int_vector 0; pending 0; in_service 0; src_d 0.
- A source held high across reset release registers a rise on the first clock edge.
- Latency:
  - irq_src high before edge k (low before k-1) -> pending set after edge k.
  - int_req high after edge k+1: 2 cycles total.
- Ack:
  - int_ack high at edge m with int_req = 1 -> int_req low after m; in_service updated after m.
  - Earliest re-request is after edge m+1, and only by a strictly higher source.
- Withdraw happens at the first edge where its condition holds. int_req is low after that edge.
- Level-held sources generate exactly one pending edge. A new edge requires a low cycle first.

## Structure
- Shared package int_pkg:
  - state enum {IDLE, REQ}.
  - Default vector constants VEC0..VEC2.
  - N_SRC.
- One sub-module, int_prio_enc3: combinational highest-set-bit encoder. It returns index and valid, and is used twice: once for winner selection, once for top in-service level.

## Test plan
- Single source:
  - irq_src = 3'b010 for one cycle, mask = 3'b111, disable = 0 -> int_req rises 2 cycles later with int_id = 1 and int_vector = 32'h600.
  - ack -> pending = 0, in_service = 3'b010.
  - eret -> in_service = 0.
- Priority and nesting:
  - Sources 0 and 2 rise together -> presents id 2 (32'h400).
  - After ack, id 0 is not requested while in_service = 3'b100.
  - After eret -> id 0 is presented (32'h800).
- Preemption:
  - With in_service = 3'b001, source 2 rises -> request id 2.
  - After ack, in_service = 3'b101.
  - Two erets -> 3'b001, then 3'b000.
- Withdraw:
  - In REQ for id 1, assert int_disable -> int_req low next edge; pending[1] still 1.
  - Deassert int_disable -> request id 1 again.
- Boundaries:
  - int_ack in IDLE -> no change.
  - eret with in_service = 0 -> no change.
  - Rise of the acked source on the ack edge -> pending bit stays 1.
- Reset:
  - Assert rst_n = 0 mid-REQ -> all outputs 0 immediately.
  - Release with irq_src = 3'b100 held -> int_req with id 2 after 2 edges.
